alu_system: RTL and testbench
=============================

// Module: alu_system
// PURPOSE
//   8-bit datapath for the course CPU, with four storage blocks:
//     register file (RF: R1-R4, T1-T4); address register file (ARF: PC, AR, SP, PCpast);
//     16-bit instruction register (IR); 256x8 memory.
//   An ALU and three muxes join these blocks.
//   All control arrives as raw select/enable inputs each cycle. There is no decoder in this block.
// PARAMETERS
//   None. Data is 8 bits, IR is 16 bits, memory is 256x8.
// PORTS
//   Clock        in   1   single clock; all state updates on its rising edge
//   Reset        in   1   synchronous, active-high; clears RF, ARF, IR and flags (not memory)
//   RF_OutASel   in   3   O1 source: 000 T1, 001 T2, 010 T3, 011 T4, 100 R1, 101 R2, 110 R3, 111 R4
//   RF_OutBSel   in   3   O2 source, same encoding as RF_OutASel
//   RF_FunSel    in   2   00 clear, 01 load MuxA, 10 decrement, 11 increment
//   RF_RSel      in   4   R enables: [3]R1 [2]R2 [1]R3 [0]R4
//   RF_TSel      in   4   T enables: [3]T1 [2]T2 [1]T3 [0]T4
//   ALU_FunSel   in   4   ALU operation (see BEHAVIOUR)
//   ARF_OutASel  in   2   OutA source: 00 AR, 01 SP, 10 PCpast, 11 PC
//   ARF_OutBSel  in   2   OutB source (memory address), same encoding as ARF_OutASel
//   ARF_FunSel   in   2   00 clear, 01 load MuxB, 10 decrement, 11 increment
//   ARF_RSel     in   4   enables: [3]PC [2]AR [1]SP [0]PCpast
//   IR_LH        in   1   load half: 0 writes IR[7:0], 1 writes IR[15:8]
//   IR_Enable    in   1   IR update enable
//   IR_Funsel    in   2   00 clear, 01 load MEM_out into the half chosen by IR_LH, 10 dec, 11 inc (16-bit)
//   Mem_WR       in   1   1 = write, 0 = read
//   Mem_CS       in   1   chip select, active-low
//   MuxASel      in   2   RF load source: 00 ALU out, 01 MEM_out, 10 IR[7:0], 11 ARF OutA
//   MuxBSel      in   2   ARF load source, same encoding as MuxASel
//   MuxCSel      in   1   ALU A input: 0 RF O1, 1 ARF OutA
//   out          out  8   ALU result
//   p_RF_O1, p_RF_O2, p_ALU_Out, p_ARF_OutA, p_MEM_Address, p_MEM_Out,
//   p_MUXA_Out, p_MUXB_Out, p_MUXC_Out    out 8 each   debug copies of internal nets
//   p_ALU_ZCNO   out  4   flags {Z,C,N,O}
//   p_IR_Out     out  16  IR contents
// BEHAVIOUR
//   Internal nets are probed hierarchically by the bench and must carry exactly these names:
//     RF_O1, RF_O2, OutALU, ALU_ZCNO, ARF_OutA, MEM_address, MEM_out, IR_out, MUXA_out, MUXB_out, MUXC_out.
//   Registers (RF, ARF, IR):
//     - update only on the rising edge, and only when their enable bit is set; otherwise hold;
//     - several enables may be set at once, and every enabled register applies the same FunSel;
//     - inc/dec wrap modulo 2^width (00-1 = FF; FFFF+1 = 0000);
//     - IR load writes only the selected half; the other half holds.
//   Reset=1 at an edge:
//     - forces all RF, ARF and IR registers and the flags to 0;
//     - overrides every FunSel and enable;
//     - memory contents are unaffected.
//   Datapath timing:
//     - muxes, RF/ARF outputs and OutALU are combinational (same-cycle);
//     - register writes are visible on the next cycle.
//   ALU (A = MUXC_out, B = RF_O2):
//     - 0000 A; 0001 B; 0010 ~A; 0011 ~B;
//     - 0100 A+B; 0101 A+B+Cflag; 0110 A-B (= A+~B+1);
//     - 0111 A&B; 1000 A|B; 1001 A^B;
//     - 1010 LSL A; 1011 LSR A; 1100 ASL A; 1101 ASR A (sign kept);
//     - 1110 CSL (rotate left through C); 1111 CSR (rotate right through C).
//   Flags register ZCNO, updated at every rising edge from the current op:
//     - Z = (result == 0);
//     - N = result[7];
//     - C = carry-out for add/sub, shifted-out bit for shifts and rotates, otherwise held;
//     - O = signed overflow for add/sub/ASL, otherwise held.
//   Memory:
//     - MEM_address = ARF OutB; write data = OutALU;
//     - Mem_CS=0 and Mem_WR=1: write at the rising edge;
//     - Mem_CS=0 and Mem_WR=0: MEM_out = mem[addr], combinational;
//     - Mem_CS=1: MEM_out = 0;
//     - contents are uninitialised unless preloaded.
// TESTING
//   1. Reset=1 for one edge -> every RF/ARF register, IR_out and ALU_ZCNO read 0.
//   2. IR_Funsel=01, IR_LH=0, mem[0]=0x2A, Mem_CS=0, Mem_WR=0; next cycle MuxASel=10, FunSel=01, RSel=1000
//      -> R1=0x2A.
//   3. R1=0x80, R2=0x80; ALU_FunSel=0100, O1=R1, O2=R2 -> OutALU=0x00; after the edge Z=1, C=1, N=0, O=1.
//   4. PC=0xFF; ARF_FunSel=11, RSel=1000 -> PC=0x00.
//      Then ARF_FunSel=10 with RSel=0100 and AR=0x00 -> AR=0xFF.
//   5. AR=0x10 (OutBSel=00), OutALU=0x55, Mem_CS=0, Mem_WR=1 for one edge -> mem[0x10]=0x55.
//      Readback with Mem_WR=0 -> MEM_out=0x55; with Mem_CS=1 -> MEM_out=0.
//   6. R1=0x81, ALU_FunSel=1101 -> 0xC0 with C=1 after the edge.
//      With Reset=1 and RF_FunSel=11 on the same edge -> registers 0, not incremented.

Source files
------------

// File: rtl/alu_system.sv
// Course-CPU datapath: RF, ARF, IR, 256x8 memory, ALU and three source muxes under raw control.
// Muxes/ALU/memory read are same-cycle; registers, flags and memory writes land on the next edge; no backpressure.
module alu_system (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  RF_OutASel,
  input  logic [2:0]  RF_OutBSel,
  input  logic [1:0]  RF_FunSel,
  input  logic [3:0]  RF_RSel,
  input  logic [3:0]  RF_TSel,
  input  logic [3:0]  ALU_FunSel,
  input  logic [1:0]  ARF_OutASel,
  input  logic [1:0]  ARF_OutBSel,
  input  logic [1:0]  ARF_FunSel,
  input  logic [3:0]  ARF_RSel,
  input  logic        IR_LH,
  input  logic        IR_Enable,
  input  logic [1:0]  IR_Funsel,
  input  logic        Mem_WR,
  input  logic        Mem_CS,
  input  logic [1:0]  MuxASel,
  input  logic [1:0]  MuxBSel,
  input  logic        MuxCSel,
  output logic [7:0]  out,
  output logic [7:0]  p_RF_O1,
  output logic [7:0]  p_RF_O2,
  output logic [7:0]  p_ALU_Out,
  output logic [7:0]  p_ARF_OutA,
  output logic [7:0]  p_MEM_Address,
  output logic [7:0]  p_MEM_Out,
  output logic [7:0]  p_MUXA_Out,
  output logic [7:0]  p_MUXB_Out,
  output logic [7:0]  p_MUXC_Out,
  output logic [3:0]  p_ALU_ZCNO,
  output logic [15:0] p_IR_Out
);

  // RF slots are indexed by their select code: 0-3 = T1-T4, 4-7 = R1-R4.
  logic [7:0]  rf [0:7];
  // ARF slots are indexed by their select code: 0 AR, 1 SP, 2 PCpast, 3 PC.
  logic [7:0]  arf [0:3];
  logic [7:0]  mem [0:255];

  logic [7:0]  RF_O1, RF_O2, OutALU, ARF_OutA, MEM_address, MEM_out;
  logic [7:0]  MUXA_out, MUXB_out, MUXC_out;
  logic [15:0] IR_out;
  logic [3:0]  ALU_ZCNO;

  logic [7:0]  rf_en;
  logic [3:0]  arf_en;
  logic [7:0]  alu_a, alu_b, res;
  logic [8:0]  sum;
  logic        c_next, o_next;

  function automatic logic [7:0] next8(input logic [1:0] fs, input logic [7:0] cur,
                                       input logic [7:0] din);
    case (fs)
      2'b00:   next8 = 8'h00;
      2'b01:   next8 = din;
      2'b10:   next8 = cur - 8'd1;
      default: next8 = cur + 8'd1;
    endcase
  endfunction

  // Enable vectors reordered so bit i enables slot i.
  assign rf_en  = {RF_RSel[0], RF_RSel[1], RF_RSel[2], RF_RSel[3],
                   RF_TSel[0], RF_TSel[1], RF_TSel[2], RF_TSel[3]};
  assign arf_en = {ARF_RSel[3], ARF_RSel[0], ARF_RSel[1], ARF_RSel[2]};

  assign RF_O1       = rf[RF_OutASel];
  assign RF_O2       = rf[RF_OutBSel];
  assign ARF_OutA    = arf[ARF_OutASel];
  assign MEM_address = arf[ARF_OutBSel];
  assign MEM_out     = (!Mem_CS && !Mem_WR) ? mem[MEM_address] : 8'h00;
  assign MUXC_out    = MuxCSel ? ARF_OutA : RF_O1;

  always_comb begin
    MUXA_out = OutALU;
    case (MuxASel)
      2'b00:   MUXA_out = OutALU;
      2'b01:   MUXA_out = MEM_out;
      2'b10:   MUXA_out = IR_out[7:0];
      default: MUXA_out = ARF_OutA;
    endcase
  end

  always_comb begin
    MUXB_out = OutALU;
    case (MuxBSel)
      2'b00:   MUXB_out = OutALU;
      2'b01:   MUXB_out = MEM_out;
      2'b10:   MUXB_out = IR_out[7:0];
      default: MUXB_out = ARF_OutA;
    endcase
  end

  assign alu_a = MUXC_out;
  assign alu_b = RF_O2;

  // C and O hold their previous value unless the op defines them.
  always_comb begin
    sum    = 9'd0;
    res    = alu_a;
    c_next = ALU_ZCNO[2];
    o_next = ALU_ZCNO[0];
    case (ALU_FunSel)
      4'h0: res = alu_a;
      4'h1: res = alu_b;
      4'h2: res = ~alu_a;
      4'h3: res = ~alu_b;
      4'h4: begin
        sum    = {1'b0, alu_a} + {1'b0, alu_b};
        res    = sum[7:0];
        c_next = sum[8];
        o_next = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      4'h5: begin
        sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, ALU_ZCNO[2]};
        res    = sum[7:0];
        c_next = sum[8];
        o_next = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      4'h6: begin
        sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        res    = sum[7:0];
        c_next = sum[8];
        o_next = (alu_a[7] != alu_b[7]) && (sum[7] != alu_a[7]);
      end
      4'h7: res = alu_a & alu_b;
      4'h8: res = alu_a | alu_b;
      4'h9: res = alu_a ^ alu_b;
      4'hA: begin
        res    = {alu_a[6:0], 1'b0};
        c_next = alu_a[7];
      end
      4'hB: begin
        res    = {1'b0, alu_a[7:1]};
        c_next = alu_a[0];
      end
      4'hC: begin
        res    = {alu_a[6:0], 1'b0};
        c_next = alu_a[7];
        o_next = alu_a[7] ^ alu_a[6];
      end
      4'hD: begin
        res    = {alu_a[7], alu_a[7:1]};
        c_next = alu_a[0];
      end
      4'hE: begin
        res    = {alu_a[6:0], ALU_ZCNO[2]};
        c_next = alu_a[7];
      end
      default: begin
        res    = {ALU_ZCNO[2], alu_a[7:1]};
        c_next = alu_a[0];
      end
    endcase
  end

  assign OutALU = res;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++)
        if (rf_en[i]) rf[i] <= next8(RF_FunSel, rf[i], MUXA_out);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) arf[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++)
        if (arf_en[i]) arf[i] <= next8(ARF_FunSel, arf[i], MUXB_out);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      IR_out <= 16'h0000;
    end else if (IR_Enable) begin
      case (IR_Funsel)
        2'b00: IR_out <= 16'h0000;
        2'b01: begin
          if (IR_LH) IR_out[15:8] <= MEM_out;
          else       IR_out[7:0]  <= MEM_out;
        end
        2'b10:   IR_out <= IR_out - 16'd1;
        default: IR_out <= IR_out + 16'd1;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) ALU_ZCNO <= 4'h0;
    else       ALU_ZCNO <= {OutALU == 8'h00, c_next, OutALU[7], o_next};
  end

  // Memory is deliberately outside reset so preloaded contents survive it.
  always_ff @(posedge Clock) begin
    if (!Mem_CS && Mem_WR) mem[MEM_address] <= OutALU;
  end

  assign out           = OutALU;
  assign p_RF_O1       = RF_O1;
  assign p_RF_O2       = RF_O2;
  assign p_ALU_Out     = OutALU;
  assign p_ARF_OutA    = ARF_OutA;
  assign p_MEM_Address = MEM_address;
  assign p_MEM_Out     = MEM_out;
  assign p_MUXA_Out    = MUXA_out;
  assign p_MUXB_Out    = MUXB_out;
  assign p_MUXC_Out    = MUXC_out;
  assign p_ALU_ZCNO    = ALU_ZCNO;
  assign p_IR_Out      = IR_out;

endmodule

// File: tb/tb_alu_system.sv
// Bench for alu_system: directed scenarios plus random control words, all checked against a cycle model.
module tb_alu_system;
  logic        Clock;
  logic        Reset;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [7:0]  out, p_RF_O1, p_RF_O2, p_ALU_Out, p_ARF_OutA, p_MEM_Address, p_MEM_Out;
  logic [7:0]  p_MUXA_Out, p_MUXB_Out, p_MUXC_Out;
  logic [3:0]  p_ALU_ZCNO;
  logic [15:0] p_IR_Out;

  alu_system dut (
    .Clock(Clock), .Reset(Reset), .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
    .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .out(out), .p_RF_O1(p_RF_O1), .p_RF_O2(p_RF_O2), .p_ALU_Out(p_ALU_Out),
    .p_ARF_OutA(p_ARF_OutA), .p_MEM_Address(p_MEM_Address), .p_MEM_Out(p_MEM_Out),
    .p_MUXA_Out(p_MUXA_Out), .p_MUXB_Out(p_MUXB_Out), .p_MUXC_Out(p_MUXC_Out),
    .p_ALU_ZCNO(p_ALU_ZCNO), .p_IR_Out(p_IR_Out)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference state: m_rf[0..3]=T1..T4, m_rf[4..7]=R1..R4; m_arf by name AR,SP,PCpast,PC.
  logic [7:0]  m_rf [8];
  logic [7:0]  m_arf [4];
  logic [15:0] m_ir;
  logic [3:0]  m_f;
  logic [7:0]  m_mem [256];
  bit          m_known [256];
  int          arf_bit [4] = '{2, 1, 0, 3};

  logic [7:0]  e_o1, e_o2, e_arfa, e_addr, e_muxc, e_alu, e_mem, e_muxa, e_muxb;
  logic        e_cw, e_c, e_ow, e_o, e_memok;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic oor(input int v);
    return (v > 127) || (v < -128);
  endfunction

  function automatic void alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                  input logic cin, output logic [7:0] r, output logic cw,
                                  output logic c, output logic ow, output logic o);
    int ua, ub, sa, sb, ci, t;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    ci = cin ? 1 : 0;
    t = 0; cw = 1'b0; c = 1'b0; ow = 1'b0; o = 1'b0;
    case (op)
      4'd0:  t = ua;
      4'd1:  t = ub;
      4'd2:  t = 255 - ua;
      4'd3:  t = 255 - ub;
      4'd4:  begin t = ua + ub;      cw = 1; c = (t > 255); ow = 1; o = oor(sa + sb); end
      4'd5:  begin t = ua + ub + ci; cw = 1; c = (t > 255); ow = 1; o = oor(sa + sb + ci); end
      4'd6:  begin t = ua - ub + 256; cw = 1; c = (ua >= ub); ow = 1; o = oor(sa - sb); end
      4'd7:  t = ua & ub;
      4'd8:  t = ua | ub;
      4'd9:  t = ua ^ ub;
      4'd10: begin t = ua * 2;          cw = 1; c = (ua >= 128); end
      4'd11: begin t = ua / 2;          cw = 1; c = (ua % 2 == 1); end
      4'd12: begin t = ua * 2;          cw = 1; c = (ua >= 128); ow = 1; o = oor(sa * 2); end
      4'd13: begin t = sa >>> 1;        cw = 1; c = (ua % 2 == 1); end
      4'd14: begin t = ua * 2 + ci;     cw = 1; c = (ua >= 128); end
      default: begin t = ua / 2 + 128 * ci; cw = 1; c = (ua % 2 == 1); end
    endcase
    r = t[7:0];
  endfunction

  task automatic model_comb();
    e_o1   = m_rf[RF_OutASel];
    e_o2   = m_rf[RF_OutBSel];
    e_arfa = m_arf[ARF_OutASel];
    e_addr = m_arf[ARF_OutBSel];
    e_muxc = MuxCSel ? e_arfa : e_o1;
    alu_ref(e_muxc, e_o2, ALU_FunSel, m_f[2], e_alu, e_cw, e_c, e_ow, e_o);
    e_mem = 8'h00;
    e_memok = 1'b1;
    if (!Mem_CS && !Mem_WR) begin
      e_mem = m_mem[e_addr];
      e_memok = m_known[e_addr];
    end
    e_muxa = (MuxASel == 2'd0) ? e_alu : (MuxASel == 2'd1) ? e_mem :
             (MuxASel == 2'd2) ? m_ir[7:0] : e_arfa;
    e_muxb = (MuxBSel == 2'd0) ? e_alu : (MuxBSel == 2'd1) ? e_mem :
             (MuxBSel == 2'd2) ? m_ir[7:0] : e_arfa;
  endtask

  function automatic logic [7:0] apply(input logic [1:0] fs, input logic [7:0] v, input logic [7:0] d);
    case (fs)
      2'd0:    return 8'h00;
      2'd1:    return d;
      2'd2:    return v - 8'd1;
      default: return v + 8'd1;
    endcase
  endfunction

  task automatic model_update();
    if (!Mem_CS && Mem_WR) begin
      m_mem[e_addr] = e_alu;
      m_known[e_addr] = 1'b1;
    end
    if (Reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      for (int i = 0; i < 4; i++) m_arf[i] = 8'h00;
      m_ir = 16'h0000;
      m_f = 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (RF_TSel[3-i]) m_rf[i] = apply(RF_FunSel, m_rf[i], e_muxa);
        if (RF_RSel[3-i]) m_rf[4+i] = apply(RF_FunSel, m_rf[4+i], e_muxa);
        if (ARF_RSel[arf_bit[i]]) m_arf[i] = apply(ARF_FunSel, m_arf[i], e_muxb);
      end
      if (IR_Enable) begin
        case (IR_Funsel)
          2'd0: m_ir = 16'h0000;
          2'd1: m_ir = IR_LH ? {e_mem, m_ir[7:0]} : {m_ir[15:8], e_mem};
          2'd2: m_ir = m_ir - 16'd1;
          default: m_ir = m_ir + 16'd1;
        endcase
      end
      m_f[3] = (e_alu == 8'h00);
      m_f[1] = e_alu[7];
      if (e_cw) m_f[2] = e_c;
      if (e_ow) m_f[0] = e_o;
    end
  endtask

  // One clock: compare every probe against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    @(negedge Clock);
    model_comb();
    chk("RF_O1", 16'(dut.RF_O1), 16'(e_o1));
    chk("RF_O2", 16'(dut.RF_O2), 16'(e_o2));
    chk("OutALU", 16'(dut.OutALU), 16'(e_alu));
    chk("ARF_OutA", 16'(dut.ARF_OutA), 16'(e_arfa));
    chk("MEM_address", 16'(dut.MEM_address), 16'(e_addr));
    chk("MUXC_out", 16'(dut.MUXC_out), 16'(e_muxc));
    chk("ALU_ZCNO", 16'(dut.ALU_ZCNO), 16'(m_f));
    chk("IR_out", dut.IR_out, m_ir);
    if (e_memok) begin
      chk("MEM_out", 16'(dut.MEM_out), 16'(e_mem));
      chk("p_MEM_Out", 16'(p_MEM_Out), 16'(e_mem));
    end
    if (e_memok || MuxASel != 2'd1) chk("MUXA_out", 16'(dut.MUXA_out), 16'(e_muxa));
    if (e_memok || MuxBSel != 2'd1) chk("MUXB_out", 16'(dut.MUXB_out), 16'(e_muxb));
    chk("out", 16'(out), 16'(e_alu));
    chk("p_ports", {p_RF_O1, p_RF_O2}, {e_o1, e_o2});
    chk("p_alu_arf", {p_ALU_Out, p_ARF_OutA}, {e_alu, e_arfa});
    chk("p_addr_muxc", {p_MEM_Address, p_MUXC_Out}, {e_addr, e_muxc});
    chk("p_flags", 16'(p_ALU_ZCNO), 16'(m_f));
    chk("p_IR_Out", p_IR_Out, m_ir);
    @(posedge Clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    Reset = 0; RF_OutASel = 0; RF_OutBSel = 0; RF_FunSel = 0; RF_RSel = 0; RF_TSel = 0;
    ALU_FunSel = 0; ARF_OutASel = 0; ARF_OutBSel = 0; ARF_FunSel = 0; ARF_RSel = 0;
    IR_LH = 0; IR_Enable = 0; IR_Funsel = 0; Mem_WR = 0; Mem_CS = 1;
    MuxASel = 0; MuxBSel = 0; MuxCSel = 0;
  endtask

  // Builds a constant in T1 by shift-left then optional increment, MSB first.
  task automatic load_t1(input logic [7:0] val);
    idle(); RF_TSel = 4'b1000; RF_FunSel = 2'b00; cycle();
    for (int b = 7; b >= 0; b--) begin
      idle(); ALU_FunSel = 4'b1010; RF_TSel = 4'b1000; RF_FunSel = 2'b01; cycle();
      if (val[b]) begin
        idle(); RF_TSel = 4'b1000; RF_FunSel = 2'b11; cycle();
      end
    end
  endtask

  task automatic t1_to_rf(input logic [3:0] rsel, input logic [3:0] tsel);
    idle(); RF_RSel = rsel; RF_TSel = tsel; RF_FunSel = 2'b01; cycle();
  endtask

  task automatic t1_to_arf(input logic [3:0] rsel);
    idle(); ARF_RSel = rsel; ARF_FunSel = 2'b01; cycle();
  endtask

  task automatic write_mem(input logic [7:0] addr, input logic [7:0] val);
    load_t1(addr);
    t1_to_arf(4'b0100);
    load_t1(val);
    idle(); Mem_CS = 0; Mem_WR = 1; cycle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    for (int i = 0; i < 4; i++) m_arf[i] = 8'h00;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_ir = 16'h0000;
    m_f = 4'h0;
    idle();
    Reset = 1;
    RF_FunSel = 2'b11; RF_RSel = 4'b1111; RF_TSel = 4'b1111;
    cycle();
    chk("rst_flags", 16'(p_ALU_ZCNO), 16'h0);
    chk("rst_ir", p_IR_Out, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      idle(); RF_OutASel = 3'(i); ARF_OutASel = 2'(i % 4); cycle();
      chk("rst_rf", 16'(p_RF_O1), 16'h00);
      chk("rst_arf", 16'(p_ARF_OutA), 16'h00);
    end

    // IR load from memory, then into R1 via MuxA
    write_mem(8'h00, 8'h2A);
    idle(); Mem_CS = 0; IR_Enable = 1; IR_Funsel = 2'b01; IR_LH = 0; cycle();
    chk("ir_low_load", p_IR_Out, 16'h002A);
    idle(); MuxASel = 2'b10; RF_FunSel = 2'b01; RF_RSel = 4'b1000; RF_OutASel = 3'b100; cycle();
    chk("r1_from_ir", 16'(p_RF_O1), 16'h2A);
    idle(); Mem_CS = 0; IR_Enable = 1; IR_Funsel = 2'b01; IR_LH = 1; cycle();
    chk("ir_high_load", p_IR_Out, 16'h2A2A);

    // 0x80 + 0x80: zero, carry, overflow
    load_t1(8'h80);
    t1_to_rf(4'b1100, 4'b0000);
    idle(); RF_OutASel = 3'b100; RF_OutBSel = 3'b101; ALU_FunSel = 4'b0100; cycle();
    chk("add_out", 16'(out), 16'h00);
    chk("add_zcno", 16'(p_ALU_ZCNO), 16'b1101);

    // ARF and IR wrap-around
    load_t1(8'hFF);
    t1_to_arf(4'b1000);
    idle(); ARF_RSel = 4'b1000; ARF_FunSel = 2'b11; ARF_OutASel = 2'b11; cycle();
    chk("pc_inc_wrap", 16'(p_ARF_OutA), 16'h00);
    idle(); ARF_RSel = 4'b0100; ARF_FunSel = 2'b00; cycle();
    idle(); ARF_RSel = 4'b0100; ARF_FunSel = 2'b10; cycle();
    chk("ar_dec_wrap", 16'(p_ARF_OutA), 16'hFF);
    idle(); IR_Enable = 1; IR_Funsel = 2'b00; cycle();
    idle(); IR_Enable = 1; IR_Funsel = 2'b10; cycle();
    chk("ir_dec_wrap", p_IR_Out, 16'hFFFF);
    idle(); IR_Enable = 1; IR_Funsel = 2'b11; cycle();
    chk("ir_inc_wrap", p_IR_Out, 16'h0000);

    // Memory write, read-back and chip-select gating
    write_mem(8'h10, 8'h55);
    idle(); Mem_CS = 0; cycle();
    chk("mem_readback", 16'(p_MEM_Out), 16'h55);
    chk("mem_addr", 16'(p_MEM_Address), 16'h10);
    idle(); Mem_CS = 1; cycle();
    chk("mem_cs_off", 16'(p_MEM_Out), 16'h00);

    // ASR keeps sign, then reset beats a same-edge increment
    load_t1(8'h81);
    t1_to_rf(4'b1000, 4'b0000);
    idle(); RF_OutASel = 3'b100; ALU_FunSel = 4'b1101; cycle();
    chk("asr_out", 16'(out), 16'hC0);
    chk("asr_carry", 16'(p_ALU_ZCNO[2]), 16'h1);
    idle(); Reset = 1; RF_FunSel = 2'b11; RF_RSel = 4'b1111; RF_TSel = 4'b1111; RF_OutASel = 3'b100;
    cycle();
    chk("rst_over_inc", 16'(p_RF_O1), 16'h00);

    // Fill all of memory with i ^ 0x5A so random reads are fully predictable
    load_t1(8'h5A);
    t1_to_rf(4'b0000, 4'b0100);
    idle(); RF_TSel = 4'b1000; RF_FunSel = 2'b00; ARF_RSel = 4'b0100; ARF_FunSel = 2'b00; cycle();
    for (int i = 0; i < 256; i++) begin
      idle(); RF_OutBSel = 3'b001; ALU_FunSel = 4'b1001; Mem_CS = 0; Mem_WR = 1;
      RF_TSel = 4'b1000; RF_FunSel = 2'b11; ARF_RSel = 4'b0100; ARF_FunSel = 2'b11;
      cycle();
    end

    repeat (1500) begin
      Reset       = ($urandom_range(0, 39) == 0);
      RF_OutASel  = 3'($urandom);  RF_OutBSel  = 3'($urandom);
      RF_FunSel   = 2'($urandom);  RF_RSel     = 4'($urandom);  RF_TSel = 4'($urandom);
      ALU_FunSel  = 4'($urandom);
      ARF_OutASel = 2'($urandom);  ARF_OutBSel = 2'($urandom);
      ARF_FunSel  = 2'($urandom);  ARF_RSel    = 4'($urandom);
      IR_LH       = 1'($urandom);  IR_Enable   = 1'($urandom);  IR_Funsel = 2'($urandom);
      Mem_WR      = 1'($urandom);  Mem_CS      = 1'($urandom);
      MuxASel     = 2'($urandom);  MuxBSel     = 2'($urandom);  MuxCSel   = 1'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
